// File: rtl/pipe_skeleton.sv
// -----------------------------------------------------------------------------
// pipe_skeleton
//
// An in-order pipeline of DEPTH one-entry stages that carries a WIDTH-bit
// payload, such as pc + inst for debug tracing. Stage 0 is the youngest stage.
// Stage DEPTH-1 presents the payload to the retire side.
//
// The ready chain is fully combinational, so an empty stage (a bubble)
// collapses in the same cycle. A payload that is accepted into an unstalled
// pipeline appears at the output DEPTH cycles later.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   in_valid     upstream (fetch) offers in_data
//   in_data      offered payload
//   in_ready     stage 0 accepts this cycle
//   out_valid    last stage presents out_data
//   out_data     last-stage payload
//   out_ready    downstream (retire) accepts
//   stall_i[k]   hold stage k contents in place
//   flush_i[k]   squash stage k and every younger stage 0..k-1
//   stage_valid  registered valid bit of each stage
//   occupancy    registered count of valid stages
//   retire_cnt   completed output handshakes (wraps)
// -----------------------------------------------------------------------------
module pipe_skeleton #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 5   // legal range 2..16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_data,
  input  logic                         out_ready,
  input  logic [DEPTH-1:0]             stall_i,
  input  logic [DEPTH-1:0]             flush_i,
  output logic [DEPTH-1:0]             stage_valid,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic [31:0]                  retire_cnt
);

  localparam int OCC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0] v_q, v_d;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [DEPTH-1:0] load;
  logic [DEPTH-1:0] kill, leave, accept;
  logic             out_valid_w, in_ready_w;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [31:0]      retire_cnt_q;

  // ---------------------------------------------------------------------------
  // Kill / leave / accept chain.
  // A flush at stage k also kills every younger stage. The ready chain is
  // evaluated from the oldest stage down to the youngest. A stage can take a
  // new payload if it is empty or if its own payload moves on this cycle.
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    kill        = '0;
    leave       = '0;
    accept      = '0;
    out_valid_w = 1'b0;
    in_ready_w  = 1'b0;

    kill[DEPTH-1] = flush_i[DEPTH-1];
    for (int k = DEPTH-2; k >= 0; k--) begin
      kill[k] = flush_i[k] | kill[k+1];
    end

    out_valid_w     = v_q[DEPTH-1] & ~kill[DEPTH-1] & ~stall_i[DEPTH-1];
    leave[DEPTH-1]  = out_valid_w & out_ready;
    accept[DEPTH-1] = ~v_q[DEPTH-1] | leave[DEPTH-1];
    for (int k = DEPTH-2; k >= 0; k--) begin
      leave[k]  = v_q[k] & ~kill[k] & ~stall_i[k] & accept[k+1];
      accept[k] = ~v_q[k] | leave[k];
    end

    // Gating with rst keeps the stage from accepting while it is held in reset.
    in_ready_w = accept[0] & ~kill[0] & ~rst;
  end

  // ---------------------------------------------------------------------------
  // Next-state valid bits and the load enables.
  // A load always wins. A killed stage can never be loaded, because the stage
  // feeding it is killed as well.
  // ---------------------------------------------------------------------------
  always_comb begin
    v_d  = v_q;
    load = '0;

    load[0] = in_valid & in_ready_w;
    for (int k = 1; k < DEPTH; k++) begin
      load[k] = leave[k-1];
    end

    for (int k = 0; k < DEPTH; k++) begin
      if (load[k]) begin
        v_d[k] = 1'b1;
      end else if (leave[k] || kill[k]) begin
        v_d[k] = 1'b0;
      end
    end

    occ_d = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occ_d = occ_d + OCC_W'(v_d[k]);
    end
  end

  // ---------------------------------------------------------------------------
  // Control state: valid bits, occupancy and the retire counter.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments, so every flop samples the pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q          <= '0;
      occ_q        <= '0;
      retire_cnt_q <= '0;
    end else begin
      v_q   <= v_d;
      occ_q <= occ_d;
      if (leave[DEPTH-1]) begin
        retire_cnt_q <= retire_cnt_q + 32'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Payload registers. A payload changes only on a load. A squashed stage
  // keeps its stale data with its valid bit cleared.
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic [WIDTH-1:0] src;
    if (g == 0) begin : g_head
      assign src = in_data;
    end else begin : g_body
      assign src = d_q[g-1];
    end

    // NOTE: the payload array is reset on purpose, so that nothing from the previous run is visible after reset.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        d_q[g] <= '0;
      end else if (load[g]) begin
        d_q[g] <= src;
      end
    end
  end

  assign in_ready    = in_ready_w;
  assign out_valid   = out_valid_w;
  assign out_data    = d_q[DEPTH-1];
  assign stage_valid = v_q;
  assign occupancy   = occ_q;
  assign retire_cnt  = retire_cnt_q;

endmodule

// File: tb/tb_pipe_skeleton.sv
// -----------------------------------------------------------------------------
// Testbench for pipe_skeleton (WIDTH=8, DEPTH=5).
// The reference model is a row of slots. On each cycle the oldest slot
// retires if it can, then each younger slot moves up into a slot that is now
// free, and then new input enters slot 0. Every slot at or below a flushed
// stage is emptied.
// -----------------------------------------------------------------------------
module tb_pipe_skeleton;

  localparam int W  = 8;
  localparam int D  = 5;
  localparam int OW = $clog2(D+1);

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic [W-1:0]   in_data;
  logic           in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_ready;
  logic [D-1:0]   stall_i;
  logic [D-1:0]   flush_i;
  logic [D-1:0]   stage_valid;
  logic [OW-1:0]  occupancy;
  logic [31:0]    retire_cnt;

  int checks = 0;
  int errors = 0;

  // Model state
  logic [D-1:0]  m_v;
  logic [W-1:0]  m_d [D];
  logic [31:0]   m_ret;
  int            cyc;

  // Handshakes seen on the DUT pins during the last step
  bit            hs_in_seen;
  bit            hs_out_seen;
  logic [W-1:0]  hs_out_data;

  // Expected order of retired payloads in the directed drains
  logic [W-1:0]  exp_o;
  int            nout;

  pipe_skeleton #(.WIDTH(W), .DEPTH(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .stall_i    (stall_i),
    .flush_i    (flush_i),
    .stage_valid(stage_valid),
    .occupancy  (occupancy),
    .retire_cnt (retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_v   = '0;
    m_ret = '0;
    for (int k = 0; k < D; k++) m_d[k] = '0;
  endtask

  // Inputs are applied at the negedge before this task is called. The task
  // checks the DUT against the model, steps one clock and returns at the next
  // negedge.
  task automatic step();
    logic [D-1:0] kill, nv;
    logic [W-1:0] nd [D];
    logic         ov, ir;
    logic [31:0]  nret;
    #1;
    for (int k = 0; k < D; k++) begin
      kill[k] = 1'b0;
      for (int j = k; j < D; j++) if (flush_i[j]) kill[k] = 1'b1;
    end
    ov   = m_v[D-1] && !kill[D-1] && !stall_i[D-1];
    nv   = m_v;
    nd   = m_d;
    nret = m_ret;
    if (ov && out_ready) begin
      nv[D-1] = 1'b0;
      nret    = m_ret + 32'd1;
    end
    for (int k = D-2; k >= 0; k--) begin
      if (m_v[k] && !kill[k] && !stall_i[k] && !nv[k+1]) begin
        nv[k+1] = 1'b1;
        nd[k+1] = m_d[k];
        nv[k]   = 1'b0;
      end
    end
    ir = !nv[0] && !kill[0];
    if (in_valid && ir) begin
      nv[0] = 1'b1;
      nd[0] = in_data;
    end
    nv = nv & ~kill;

    check("in_ready",    64'(in_ready),    64'(ir));
    check("out_valid",   64'(out_valid),   64'(ov));
    if (ov) check("out_data", 64'(out_data), 64'(m_d[D-1]));
    check("stage_valid", 64'(stage_valid), 64'(m_v));
    check("occupancy",   64'(occupancy),   64'($countones(m_v)));
    check("retire_cnt",  64'(retire_cnt),  64'(m_ret));

    hs_in_seen  = in_valid && in_ready;
    hs_out_seen = out_valid && out_ready;
    hs_out_data = out_data;

    @(posedge clk);
    m_v   = nv;
    m_d   = nd;
    m_ret = nret;
    cyc++;
    @(negedge clk);
  endtask

  task automatic note_out();
    if (hs_out_seen) begin
      check("out_order", 64'(hs_out_data), 64'(exp_o));
      exp_o = exp_o + 8'd1;
      nout++;
    end
  endtask

  task automatic reset_check();
    check("rst_in_ready",    64'(in_ready),    64'd0);
    check("rst_out_valid",   64'(out_valid),   64'd0);
    check("rst_out_data",    64'(out_data),    64'd0);
    check("rst_stage_valid", 64'(stage_valid), 64'd0);
    check("rst_occupancy",   64'(occupancy),   64'd0);
    check("rst_retire_cnt",  64'(retire_cnt),  64'd0);
  endtask

  initial begin
    int t_in, t_out, idx;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    stall_i   = '0;
    flush_i   = '0;
    cyc       = 0;
    model_clear();

    repeat (2) @(negedge clk);
    reset_check();
    rst = 1'b0;

    // Back-to-back stream 0x01..0x0A with out_ready=1: check latency and count.
    t_in = -1; t_out = -1;
    exp_o = 8'h01; nout = 0;
    out_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      in_valid = 1'b1;
      in_data  = W'(i);
      step();
      if (hs_in_seen && in_data == 8'h01) t_in = cyc - 1;
      if (hs_out_seen && hs_out_data == 8'h01) t_out = cyc - 1;
      note_out();
    end
    in_valid = 1'b0;
    repeat (8) begin
      step();
      if (hs_out_seen && hs_out_data == 8'h01) t_out = cyc - 1;
      note_out();
    end
    check("latency",    64'(t_out - t_in), 64'd5);
    check("stream_cnt", 64'(nout),         64'd10);
    check("retire_10",  64'(retire_cnt),   64'd10);

    // Fill the pipeline, then hold out_ready low for 3 cycles.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h11 + W'(i);
      step();
    end
    in_data = 8'h16;
    repeat (3) begin
      step();
      check("hold_occ",      64'(occupancy), 64'd5);
      check("hold_in_ready", 64'(in_ready),  64'd0);
      check("hold_out_data", 64'(out_data),  64'h11);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    exp_o = 8'h11; nout = 0;
    repeat (8) begin step(); note_out(); end
    check("hold_drain_cnt", 64'(nout), 64'd5);

    // Full pipeline, then a one-cycle flush of stage 2.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h21 + W'(i);
      step();
    end
    in_valid = 1'b0;
    flush_i  = 5'b00100;
    step();
    flush_i  = '0;
    check("flush_stage_valid", 64'(stage_valid), 64'h18);
    check("flush_occ",         64'(occupancy),   64'd2);
    out_ready = 1'b1;
    exp_o = 8'h21; nout = 0;
    repeat (6) begin step(); note_out(); end
    check("flush_drain_cnt", 64'(nout), 64'd2);

    // Stages 0 and 2 valid, stage 1 empty, stage 3 full and stalled.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h31 + W'(i);
      step();
    end
    in_valid = 1'b0;
    repeat (5) step();
    in_valid = 1'b1; in_data = 8'h34;
    step();
    check("bubble_stage_valid", 64'(stage_valid), 64'h1D);
    stall_i = 5'b01000; in_data = 8'h35;
    #1;
    check("stall_in_ready", 64'(in_ready), 64'd1);
    step();
    check("stall_stage_valid", 64'(stage_valid), 64'h1F);
    stall_i = '0; in_valid = 1'b0; out_ready = 1'b1;
    exp_o = 8'h31; nout = 0;
    repeat (8) begin step(); note_out(); end
    check("stall_drain_cnt", 64'(nout), 64'd5);

    // Retire counter wrap.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h41;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    force dut.retire_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.retire_cnt_q;
    m_ret = 32'hFFFF_FFFF;
    out_ready = 1'b1;
    step();
    check("retire_wrap", 64'(retire_cnt), 64'd0);

    // Asynchronous reset in mid-stream with 4 stages occupied.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h51 + W'(i);
      step();
    end
    in_valid = 1'b0;
    repeat (4) step();
    check("pre_rst_occ", 64'(occupancy), 64'd4);
    out_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    reset_check();
    @(negedge clk);
    model_clear();
    in_valid = 1'b1; in_data = 8'h61;
    rst = 1'b0;
    step();
    check("post_rst_accept", 64'(stage_valid), 64'h01);

    // Randomized traffic with sparse stalls and flushes.
    for (int n = 0; n < 600; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = W'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      stall_i   = '0;
      for (int k = 0; k < D; k++) stall_i[k] = ($urandom_range(0, 7) == 0);
      flush_i   = '0;
      if ($urandom_range(0, 15) == 0) begin
        idx = int'($urandom_range(0, D-1));
        flush_i[idx] = 1'b1;
      end
      step();
    end
    in_valid = 1'b0; stall_i = '0; flush_i = '0; out_ready = 1'b1;
    repeat (8) step();
    check("final_empty", 64'(stage_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_skeleton.md
PIPE_SKELETON -- requirements
Module: pipe_skeleton

Interface
REQ-001 SHALL provide parameter WIDTH, default 64, payload bits carried per stage (pc + inst for debug tracing).
REQ-002 SHALL provide parameter DEPTH, default 5, number of pipeline stages, legal range 2..16.
REQ-003 SHALL have one clock and an asynchronous, active-high reset, named as below.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have port in_valid  input  1  upstream (fetch) offers a payload.
REQ-007 SHALL have port in_data  input  WIDTH  offered payload.
REQ-008 SHALL have port in_ready  output  1  stage 0 accepts this cycle.
REQ-009 SHALL have port out_valid  output  1  last stage presents a payload.
REQ-010 SHALL have port out_data  output  WIDTH  last-stage payload.
REQ-011 SHALL have port out_ready  input  1  downstream (retire) accepts.
REQ-012 SHALL have port stall_i  input  DEPTH  bit k holds stage k contents in place.
REQ-013 SHALL have port flush_i  input  DEPTH  bit k squashes stage k and all younger stages 0..k-1.
REQ-014 SHALL have port stage_valid  output  DEPTH  registered valid bit of each stage.
REQ-015 SHALL have port occupancy  output  clog2(DEPTH+1)  count of valid stages.
REQ-016 SHALL have port retire_cnt  output  32  count of completed output handshakes.

Function
REQ-017 Stage k SHALL hold registered v[k] and d[k]; stage 0 is youngest, stage DEPTH-1 drives out_data = d[DEPTH-1].
REQ-018 kill[k] SHALL equal OR of flush_i[k..DEPTH-1], combinational.
REQ-019 out_valid SHALL equal v[DEPTH-1] AND NOT kill[DEPTH-1] AND NOT stall_i[DEPTH-1].
REQ-020 leave[DEPTH-1] SHALL equal out_valid AND out_ready; for k<DEPTH-1, leave[k] = v[k] AND NOT kill[k] AND NOT stall_i[k] AND accept[k+1].
REQ-021 accept[k] SHALL equal NOT v[k] OR leave[k]; this ready chain is combinational with zero-cycle bubble collapse.
REQ-022 in_ready SHALL equal accept[0] AND NOT kill[0].
REQ-023 On each edge stage k+1 SHALL load d[k] with v=1 when leave[k]; otherwise, if it left, v[k+1]=0; otherwise it holds.
REQ-024 Stage 0 SHALL load in_data with v=1 when in_valid AND in_ready.
REQ-025 Flush SHALL take priority over holding: a stage with kill[k]=1 SHALL have v[k]=0 at the next edge unless it loads a new payload from stage k-1 in the same cycle, which is impossible because kill[k-1]=1.
REQ-026 d[k] SHALL change only on a load; squashed stages keep stale data with v=0.
REQ-027 Per stage, latency SHALL be one cycle; an unstalled pipeline with out_ready=1 SHALL deliver an accepted payload on out_valid exactly DEPTH cycles after acceptance.
REQ-028 Full pipeline with out_ready=1 and no stall SHALL sustain one transfer per cycle (in_ready stays 1).
REQ-029 A stall at stage k SHALL back-pressure stages 0..k-1 only once they are full; bubbles upstream of k SHALL still collapse.
REQ-030 occupancy SHALL be a registered popcount of next-state valid bits, matching stage_valid each cycle.
REQ-031 retire_cnt SHALL increment by 1 per output handshake and wrap 0xFFFFFFFF -> 0.
REQ-032 Simultaneous stall_i[k] and flush_i[j] with j>=k SHALL squash stage k.
REQ-033 Simultaneous in handshake and out handshake on a full pipeline SHALL keep occupancy unchanged.

Reset
REQ-034 rst=1 SHALL immediately clear all v[k], d[k], occupancy and retire_cnt to 0, independent of clk.
REQ-035 While rst=1, out_valid SHALL be 0 and in_ready SHALL be 0; the first acceptance SHALL occur on the first edge after rst deasserts.
REQ-036 Asserting rst mid-stream SHALL discard all in-flight payloads without producing an output handshake.

Verification (WIDTH=8, DEPTH=5)
REQ-037 After reset, feed 0x01..0x0A back to back with out_ready=1 -> out_data 0x01 appears 5 cycles after its acceptance; then 1 per cycle, retire_cnt=10.
REQ-038 Fill the pipeline, hold out_ready=0 for 3 cycles -> occupancy=5, in_ready=0, out_data held; release -> in-order drain, no loss.
REQ-039 Full pipeline, pulse flush_i=5'b00100 for one cycle -> stage_valid=5'b11000 next cycle, occupancy=2, stages 0..2 payloads never appear.
REQ-040 With stages 0,2 valid and 1 empty, stall_i[3]=1 and stage 3 full -> stage 2 holds, stage 0 advances into stage 1, in_ready=1.
REQ-041 Preload retire_cnt near wrap by 2^32-1 retirements (force) then one handshake -> retire_cnt=0.
REQ-042 Assert rst asynchronously between edges while occupancy=4 -> outputs clear within the same cycle, out_valid=0, no extra retire.
